// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// mm_pkg : sequencer states, default matrix sizes and index-width helper
// Rev 1.0
// ============================================================================
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    ACC     = 3'd2,
    WB      = 3'd3,
    DONE    = 3'd4
  } mm_state_t;

  localparam int MM_ROWS  = 2;
  localparam int MM_INNER = 3;
  localparam int MM_COLS  = 2;

  // Never returns 0 so that single-entry dimensions still get a 1-bit index.
  function automatic int mm_clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_idx_counter.sv
`default_nettype none
// ============================================================================
// mm_idx_counter : nested k / col / row counter for the MAC sequencer
// Rev 1.0
// ============================================================================
module mm_idx_counter
  import mm_pkg::*;
#(
  parameter int ROWS  = MM_ROWS,
  parameter int INNER = MM_INNER,
  parameter int COLS  = MM_COLS,
  localparam int RW   = mm_clog2(ROWS),
  localparam int KW   = mm_clog2(INNER),
  localparam int CLW  = mm_clog2(COLS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           en,
  input  logic           wb_phase,
  output logic [KW-1:0]  k_nxt,
  output logic [CLW-1:0] col_nxt,
  output logic [RW-1:0]  row_nxt,
  output logic           k_last,
  output logic           elem_last
);

  logic [KW-1:0]  k;
  logic [CLW-1:0] col;
  logic [RW-1:0]  row;
  logic           col_last;
  logic           row_last;

  assign k_last    = (k == KW'(INNER - 1));
  assign col_last  = (col == CLW'(COLS - 1));
  assign row_last  = (row == RW'(ROWS - 1));
  assign elem_last = col_last && row_last;

  // k steps during accumulation; col/row step only on the write-back cycle.
  always_comb begin
    k_nxt   = k;
    col_nxt = col;
    row_nxt = row;
    if (clr) begin
      k_nxt   = '0;
      col_nxt = '0;
      row_nxt = '0;
    end else if (en) begin
      if (!wb_phase) begin
        k_nxt = k_last ? '0 : k + KW'(1);
      end else if (col_last) begin
        col_nxt = '0;
        row_nxt = row_last ? '0 : row + RW'(1);
      end else begin
        col_nxt = col + CLW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k   <= '0;
      col <= '0;
      row <= '0;
    end else begin
      k   <= k_nxt;
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// mac_sequencer : drives the shared MAC datapath to compute C = A x B
// Optional cycle counter output enabled by MAC_SEQ_PERF_CNT_EN.  Rev 1.0
// ============================================================================
module mac_sequencer
  import mm_pkg::*;
#(
  parameter int ROWS  = MM_ROWS,
  parameter int INNER = MM_INNER,
  parameter int COLS  = MM_COLS,
  localparam int AW   = mm_clog2(ROWS * INNER),
  localparam int BW   = mm_clog2(INNER * COLS),
  localparam int CW   = mm_clog2(ROWS * COLS),
  localparam int RW   = mm_clog2(ROWS),
  localparam int KW   = mm_clog2(INNER),
  localparam int CLW  = mm_clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_ready,
  input  logic          hold,
  output logic [AW-1:0] a_sel,
  output logic [BW-1:0] b_sel,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          res_we,
  output logic [CW-1:0] res_addr,
  output logic          busy,
  output logic          done
`ifdef MAC_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]   cycle_cnt
`endif
);

  mm_state_t      state;
  logic [KW-1:0]  k_nxt;
  logic [CLW-1:0] col_nxt;
  logic [RW-1:0]  row_nxt;
  logic           k_last;
  logic           elem_last;
  logic           cnt_en;
  logic           cnt_clr;
  logic [AW-1:0]  a_idx;
  logic [BW-1:0]  b_idx;
  logic [CW-1:0]  c_idx;

  assign cnt_en  = !hold && (state == ACC || state == WB);
  assign cnt_clr = (state != ACC) && (state != WB);

  mm_idx_counter #(
    .ROWS  (ROWS),
    .INNER (INNER),
    .COLS  (COLS)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .wb_phase  (state == WB),
    .k_nxt     (k_nxt),
    .col_nxt   (col_nxt),
    .row_nxt   (row_nxt),
    .k_last    (k_last),
    .elem_last (elem_last)
  );

  // Selects are registered from the counters' next values so they line up
  // with the state being entered.
  always_comb begin
    a_idx = AW'(int'(row_nxt) * INNER + int'(k_nxt));
    b_idx = BW'(int'(k_nxt) * COLS + int'(col_nxt));
    c_idx = CW'(int'(row_nxt) * COLS + int'(col_nxt));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      a_sel    <= '0;
      b_sel    <= '0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      res_we   <= 1'b0;
      res_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_IN;
            busy  <= 1'b1;
          end
        end
        WAIT_IN: begin
          if (in_ready) begin
            state    <= ACC;
            mac_en   <= 1'b1;
            mac_clr  <= 1'b1;
            a_sel    <= a_idx;
            b_sel    <= b_idx;
            res_addr <= c_idx;
          end
        end
        ACC: begin
          if (hold) begin
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
          end else if (k_last) begin
            state    <= WB;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            res_we   <= 1'b1;
            a_sel    <= a_idx;
            b_sel    <= b_idx;
            res_addr <= c_idx;
          end else begin
            mac_en   <= 1'b1;
            mac_clr  <= 1'b0;
            a_sel    <= a_idx;
            b_sel    <= b_idx;
            res_addr <= c_idx;
          end
        end
        WB: begin
          if (hold) begin
            res_we <= 1'b0;
          end else if (elem_last) begin
            state    <= DONE;
            res_we   <= 1'b0;
            done     <= 1'b1;
            a_sel    <= '0;
            b_sel    <= '0;
            res_addr <= '0;
          end else begin
            state    <= ACC;
            res_we   <= 1'b0;
            mac_en   <= 1'b1;
            mac_clr  <= 1'b1;
            a_sel    <= a_idx;
            b_sel    <= b_idx;
            res_addr <= c_idx;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) cycle_cnt <= '0;
    end else if (cycle_cnt != 16'hFFFF) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mac_sequencer : scoreboard bench for mac_sequencer (ROWS=2 INNER=3 COLS=2)
// Rev 1.0
// ============================================================================
module tb_mac_sequencer;

  localparam int ROWS  = 2;
  localparam int INNER = 3;
  localparam int COLS  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_ready = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] a_sel;
  logic [2:0] b_sel;
  logic       mac_en;
  logic       mac_clr;
  logic       res_we;
  logic [1:0] res_addr;
  logic       busy;
  logic       done;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit wr;
    int a;
    int b;
    bit clr;
    int addr;
  } ev_t;

  ev_t sbq[$];

  mac_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_ready (in_ready),
    .hold     (hold),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .res_we   (res_we),
    .res_addr (res_addr),
    .busy     (busy),
    .done     (done)
`ifdef MAC_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void push_elem(input int r, input int c, input bit wr);
    for (int k = 0; k < INNER; k++)
      sbq.push_back('{wr: 1'b0, a: r * INNER + k, b: k * COLS + c, clr: (k == 0), addr: 0});
    if (wr) sbq.push_back('{wr: 1'b1, a: 0, b: 0, clr: 1'b0, addr: r * COLS + c});
  endfunction

  function automatic void push_run();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_elem(r, c, 1'b1);
  endfunction

  // Every MAC or write operation the DUT issues must match the head of the queue.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  ok;
    if (mac_en === 1'b1 || res_we === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_op: got mac_en=%0b res_we=%0b a_sel=%0d b_sel=%0d res_addr=%0d, required no operation",
                 mac_en, res_we, a_sel, b_sel, res_addr);
      end else begin
        e = sbq.pop_front();
        if (e.wr)
          ok = (res_we === 1'b1) && (mac_en === 1'b0) && (int'(res_addr) == e.addr);
        else
          ok = (mac_en === 1'b1) && (res_we === 1'b0) && (int'(a_sel) == e.a) &&
               (int'(b_sel) == e.b) && (mac_clr === e.clr);
        if (!ok) begin
          errors++;
          $display("FAIL scoreboard: got mac_en=%0b res_we=%0b a_sel=%0d b_sel=%0d mac_clr=%0b res_addr=%0d, required wr=%0b a=%0d b=%0d clr=%0b addr=%0d",
                   mac_en, res_we, a_sel, b_sel, mac_clr, res_addr, e.wr, e.a, e.b, e.clr, e.addr);
        end
      end
    end
  end

  task automatic run_to_done(input bit use_hold, inout int cyc);
    bit held;
    held = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      if (use_hold && !held && mac_en === 1'b1 && a_sel == 3'd4 && b_sel == 3'd2) begin
        held = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          cyc++;
          checks++;
          if (mac_en !== 1'b0 || res_we !== 1'b0 || mac_clr !== 1'b0 || a_sel !== 3'd4 || b_sel !== 3'd2) begin
            errors++;
            $display("FAIL hold_freeze: got mac_en=%0b res_we=%0b mac_clr=%0b a_sel=%0d b_sel=%0d, required 0 0 0 4 2",
                     mac_en, res_we, mac_clr, a_sel, b_sel);
          end
        end
        hold = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got done=%0b after %0d cycles, required 1", done, cyc);
    end
    if (use_hold) begin
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL hold_point: got no k=1 cycle of element 2, required a_sel=4 b_sel=2 with mac_en");
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%0b busy=%0b, required 0 0", done, busy);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d pending ops, required 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; hold = 1'b1; in_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_sel, b_sel, mac_en, mac_clr, res_we, res_addr, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {a_sel, b_sel, mac_en, mac_clr, res_we, res_addr, busy, done});
    end
    start = 1'b0; hold = 1'b0; in_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    int cyc;
    push_run();
    start = 1'b1; in_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mac_en !== 1'b0) begin
      errors++;
      $display("FAIL first_busy: got busy=%0b mac_en=%0b, required 1 0", busy, mac_en);
    end
    @(negedge clk);
    cyc++;
    in_ready = 1'b0;
    checks++;
    if (mac_en !== 1'b1 || mac_clr !== 1'b1 || a_sel !== 3'd0 || b_sel !== 3'd0) begin
      errors++;
      $display("FAIL first_mac: got mac_en=%0b mac_clr=%0b a_sel=%0d b_sel=%0d, required 1 1 0 0",
               mac_en, mac_clr, a_sel, b_sel);
    end
    run_to_done(1'b0, cyc);
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("FAIL run_length: got %0d cycles to done, required 18", cyc);
    end
  endtask

  task automatic test_element_11();
    int  qa[$];
    int  qb[$];
    bit  qc[$];
    int  n;
    int  cyc;
    bit  seen;
    seen = 1'b0;
    push_run();
    start = 1'b1; in_ready = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mac_en === 1'b1) begin
        qa.push_back(int'(a_sel)); qb.push_back(int'(b_sel)); qc.push_back(mac_clr);
      end
      if (res_we === 1'b1 && res_addr == 2'd3 && qa.size() >= 3) begin
        seen = 1'b1;
        n = qa.size();
        checks++;
        if (qa[n-3] != 3 || qa[n-2] != 4 || qa[n-1] != 5) begin
          errors++;
          $display("FAIL elem11_a: got %0d %0d %0d, required 3 4 5", qa[n-3], qa[n-2], qa[n-1]);
        end
        checks++;
        if (qb[n-3] != 1 || qb[n-2] != 3 || qb[n-1] != 5) begin
          errors++;
          $display("FAIL elem11_b: got %0d %0d %0d, required 1 3 5", qb[n-3], qb[n-2], qb[n-1]);
        end
        checks++;
        if (qc[n-3] != 1'b1 || qc[n-2] != 1'b0 || qc[n-1] != 1'b0) begin
          errors++;
          $display("FAIL elem11_clr: got %0b %0b %0b, required 1 0 0", qc[n-3], qc[n-2], qc[n-1]);
        end
      end
    end
    start = 1'b0; in_ready = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL elem11_write: got no write to res_addr 3, required one");
    end
    run_to_done(1'b0, cyc);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queue: got busy=%0b after run with start held, required 0", busy);
    end
  endtask

  task automatic test_wait_in();
    int cyc;
    push_run();
    start = 1'b1; in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || mac_en !== 1'b0) begin
        errors++;
        $display("FAIL wait_in: got busy=%0b mac_en=%0b, required 1 0", busy, mac_en);
      end
    end
    start = 1'b0; in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    checks++;
    if (mac_en !== 1'b1 || mac_clr !== 1'b1) begin
      errors++;
      $display("FAIL wait_release: got mac_en=%0b mac_clr=%0b, required 1 1", mac_en, mac_clr);
    end
    cyc = 0;
    run_to_done(1'b0, cyc);
  endtask

  task automatic test_hold();
    int cyc;
    push_run();
    start = 1'b1; in_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    run_to_done(1'b1, cyc);
    in_ready = 1'b0;
    checks++;
    if (cyc != 21) begin
      errors++;
      $display("FAIL hold_length: got %0d cycles to done, required 21", cyc);
    end
  endtask

`ifdef MAC_SEQ_PERF_CNT_EN
  task automatic test_perf_cnt();
    int cyc;
    test_hold();
    checks++;
    if (cycle_cnt !== 16'd21) begin
      errors++;
      $display("FAIL perf_hold: got cycle_cnt=%0d, required 21", cycle_cnt);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cycle_cnt !== 16'd21) begin
      errors++;
      $display("FAIL perf_idle: got cycle_cnt=%0d, required 21", cycle_cnt);
    end
    push_run();
    start = 1'b1; in_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    checks++;
    if (cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_clear: got cycle_cnt=%0d, required 0", cycle_cnt);
    end
    run_to_done(1'b0, cyc);
    in_ready = 1'b0;
    checks++;
    if (cycle_cnt !== 16'd18) begin
      errors++;
      $display("FAIL perf_plain: got cycle_cnt=%0d, required 18", cycle_cnt);
    end
  endtask
`endif

  task automatic test_reset_abort();
    int cyc;
    push_elem(0, 0, 1'b1);
    push_elem(0, 1, 1'b1);
    start = 1'b1; in_ready = 1'b1;
    cyc = 0;
    while (!(res_we === 1'b1 && res_addr == 2'd1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    in_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({a_sel, b_sel, mac_en, mac_clr, res_we, res_addr, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %b, required all zero",
               {a_sel, b_sel, mac_en, mac_clr, res_we, res_addr, busy, done});
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL abort_ops: got %0d pending ops, required 0", sbq.size());
    end
    sbq.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int run = 0; run < 2; run++) begin
      push_run();
      start = 1'b1; in_ready = 1'b1;
      @(negedge clk);
      cyc = 1;
      start = 1'b0;
      run_to_done(1'b0, cyc);
      checks++;
      if (cyc != 18) begin
        errors++;
        $display("FAIL b2b_length: run %0d got %0d cycles, required 18", run, cyc);
      end
    end
    in_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_element_11();
    test_wait_in();
    test_hold();
`ifdef MAC_SEQ_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
